// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared types and constants for the fifo_drain burst reader:
//               FSM state encoding, skid-buffer geometry and default
//               parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 4;

  // The skid depth must stay a power of two: the buffer pointers wrap
  // naturally at their bit width.
  localparam int SKID_DEPTH = 4;
  localparam int PTR_W      = $clog2(SKID_DEPTH);
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_skid
// Description : 4-entry in-order skid buffer holding {data, last} words
//               between the FIFO read port and the downstream handshake.
// Ports       : clk, reset_n          - clock, async active-low reset
//               push, push_data/last  - write one entry (caller ensures room)
//               pop                   - drop head entry (caller ensures data)
//               head_data, head_last  - current head entry
//               occupancy             - number of valid entries (0..4)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem_data [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage is reset too so the downstream data/last outputs read zero
  // straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      mem_last  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_data = mem_data[rd_ptr];
  assign head_last = mem_last[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Pulls bursts of up to BURST_LEN words from an upstream FIFO
//               and presents them on a valid/ready stream with m_last
//               marking the end of each burst. Reads are buffered in a
//               4-entry skid so downstream back-pressure never drops words.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               fifo_read_en, fifo_data_out  - FIFO read strobe / data (1-cycle
//                                              read latency)
//               fifo_empty, fifo_almost_empty- FIFO status flags
//               flush                        - drain even when almost empty
//               m_data, m_valid, m_ready,
//               m_last                       - downstream stream
//               busy                         - FSM not IDLE
//               word_count                   - accepted-transfer counter,
//                                              present only when the macro
//                                              FIFO_DRAIN_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]           word_count
`endif
);

  localparam int SUM_W = OCC_W + 1;

  state_t           state;
  logic [7:0]       issued;     // reads strobed in the current burst
  logic [7:0]       captured;   // words captured in the current burst
  logic             in_flight;  // a read was strobed last cycle
  logic [OCC_W-1:0] occupancy;
  logic [SUM_W-1:0] committed;
  logic             pop;
  logic             cap_last;

  assign pop       = m_valid && m_ready;
  assign committed = SUM_W'(occupancy) + SUM_W'(in_flight);

  // A word is the burst's last if it completes BURST_LEN, or the FIFO has
  // run dry by the time it lands.
  assign cap_last  = (captured == 8'(BURST_LEN - 1)) || fifo_empty;

  // Combinational so it can never be high in a cycle where fifo_empty is.
  // No separate "last seen" flag is needed: capturing the last word moves
  // the FSM out of BURST in the same edge.
  assign fifo_read_en = (state == BURST) && !fifo_empty &&
                        (issued < 8'(BURST_LEN)) &&
                        (committed < SUM_W'(SKID_DEPTH));

  assign busy    = (state != IDLE);
  assign m_valid = (occupancy != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      issued    <= '0;
      captured  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= fifo_read_en;
      case (state)
        IDLE: begin
          issued   <= '0;
          captured <= '0;
          if (!fifo_empty && (!fifo_almost_empty || flush)) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (fifo_read_en) begin
            issued <= issued + 8'd1;
          end
          if (in_flight) begin
            captured <= captured + 8'd1;
            if (cap_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((occupancy == '0) || ((occupancy == OCC_W'(1)) && pop)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_drain_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data (fifo_data_out),
    .push_last (cap_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .occupancy (occupancy)
  );

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the word width, matching the upstream FIFO.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, the maximum number of words per output burst (range 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port fifo_read_en, output, 1, the read strobe to the FIFO.
REQ-006 The block SHALL have port fifo_data_out, input, DATA_WIDTH, FIFO read data, valid the cycle after fifo_read_en was high.
REQ-007 The block SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-008 The block SHALL have port fifo_almost_empty, input, 1, FIFO almost-empty flag.
REQ-009 The block SHALL have port flush, input, 1, level request to drain the FIFO regardless of fifo_almost_empty.
REQ-010 The block SHALL have port m_data, output, DATA_WIDTH, downstream word.
REQ-011 The block SHALL have port m_valid, output, 1, downstream word valid.
REQ-012 The block SHALL have port m_ready, input, 1, downstream accept; transfer occurs when m_valid && m_ready.
REQ-013 The block SHALL have port m_last, output, 1, marks the final word of a burst, qualified by m_valid.
REQ-014 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BURST, DRAIN.
REQ-016 IDLE->BURST SHALL occur when !fifo_empty && (!fifo_almost_empty || flush).
REQ-017 fifo_read_en SHALL equal (state==BURST) && !fifo_empty && (issued < BURST_LEN) && (skid occupancy + in-flight reads < 4) && !last_seen, and SHALL never be high while fifo_empty=1.
REQ-018 Each read word SHALL be captured into a 4-entry in-order skid buffer at the end of the cycle after its fifo_read_en cycle; m_valid SHALL rise 2 cycles after BURST entry.
REQ-019 A captured word SHALL carry last=1 if it is the BURST_LEN-th word of the burst, or if fifo_empty=1 in its capture cycle.
REQ-020 BURST->DRAIN SHALL occur on capture of a last=1 word; DRAIN->IDLE SHALL occur when the skid buffer becomes empty.
REQ-021 With m_ready held high and data available, throughput SHALL be one word per cycle.
REQ-022 m_data, m_last SHALL hold stable while m_valid && !m_ready; words SHALL never be dropped, duplicated or reordered.
REQ-023 A FIFO write coinciding with the capture cycle of a last=1 word SHALL NOT extend the burst; that word starts the next burst.

Reset
REQ-024 On reset_n=0 the block SHALL immediately force fifo_read_en=0, m_valid=0, m_data=0, m_last=0, busy=0, state=IDLE, counters=0.
REQ-025 Reset mid-burst SHALL discard buffered and in-flight words.

Configuration
REQ-026 With macro FIFO_DRAIN_CNT_EN defined, the block SHALL add output port word_count, 16 bits, counting accepted transfers, wrapping 0xFFFF->0x0000, reset 0.
REQ-027 Without FIFO_DRAIN_CNT_EN, port word_count and its counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-028 Package fifo_drain_pkg SHALL hold the FSM state enum typedef, SKID_DEPTH=4, and default DATA_WIDTH/BURST_LEN constants.
REQ-029 The skid buffer SHALL be sub-module fifo_drain_skid (4-entry, data+last, push/pop, occupancy output).

Verification
REQ-030 FIFO holding 0x0001..0x0008, almost_empty=0, m_ready=1 -> two bursts of 4 words, m_last on 0x0004 and 0x0008, no fifo_read_en while fifo_empty=1.
REQ-031 FIFO holding 3 words, almost_empty=1, flush=0 -> no fifo_read_en for 20 cycles; then flush=1 -> 0x0001..0x0003 out, m_last on third, busy returns low.
REQ-032 m_ready=0 for 10 cycles during burst -> at most 4 reads issued, m_data stable; m_ready=1 -> remaining words in order, none lost.
REQ-033 reset_n pulsed low after 2 of 4 words accepted -> all outputs 0 with no clock edge, FSM IDLE; fresh data after release drains normally.
REQ-034 With FIFO_DRAIN_CNT_EN: 6 words accepted -> word_count=6; 65537 accepted -> word_count=1.
